// File: rtl/demux_1to4_if.sv
// Bus bundle for the 1-to-4 demultiplexer: routing controls in, four data lanes
// and their one-hot activity flags out.
interface demux_1to4_if #(
  parameter int DATA_W = 1
);
  logic                  en;
  logic [DATA_W-1:0]     data_in;
  logic [1:0]            select;
  logic [4*DATA_W-1:0]   data_out;
  logic [3:0]            lane_sel;

  modport master (output en, data_in, select, input data_out, lane_sel);
  modport slave  (input en, data_in, select, output data_out, lane_sel);
endinterface

// File: rtl/demux_1to4.sv
// 1-to-4 demultiplexer: steers data_in onto the lane picked by select.
// The output stage is either registered with one cycle of latency, or purely combinational.
module demux_1to4 #(
  parameter int DATA_W  = 1,
  parameter int REG_OUT = 1,
  parameter int HOLD    = 0
) (
  input  logic          clk,
  input  logic          rst,
  demux_1to4_if.slave   bus
);

  localparam bit HOLD_EN = (HOLD != 0) && (REG_OUT != 0);

  logic [3:0]          lane_sel_c;
  logic [4*DATA_W-1:0] data_c;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    lane_sel_c = '0;
    data_c     = '0;
    if (bus.en) begin
      // An X/Z select matches no item, so it falls to the all-zero default.
      case (bus.select)
        2'd0:    lane_sel_c = 4'b0001;
        2'd1:    lane_sel_c = 4'b0010;
        2'd2:    lane_sel_c = 4'b0100;
        2'd3:    lane_sel_c = 4'b1000;
        default: lane_sel_c = 4'b0000;
      endcase
    end
    for (int k = 0; k < 4; k++) begin
      if (lane_sel_c[k]) data_c[k*DATA_W +: DATA_W] = bus.data_in;
    end
  end

  select_known_a : assert property (@(posedge clk) disable iff (rst)
    bus.en |-> !$isunknown(bus.select))
    else $error("demux_1to4: select is X/Z while en is high");

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [4*DATA_W-1:0] data_d, data_q;
      logic [3:0]          lane_sel_d, lane_sel_q;

      always_comb begin
        lane_sel_d = lane_sel_c;
        data_d     = data_q;
        for (int k = 0; k < 4; k++) begin
          if (!HOLD_EN || lane_sel_c[k]) data_d[k*DATA_W +: DATA_W] = data_c[k*DATA_W +: DATA_W];
        end
      end

      // NOTE: sequential state uses non-blocking assignments so all flops sample together.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q     <= '0;
          lane_sel_q <= '0;
        end else begin
          data_q     <= data_d;
          lane_sel_q <= lane_sel_d;
        end
      end

      assign bus.data_out = data_q;
      assign bus.lane_sel = lane_sel_q;
    end else begin : g_comb
      assign bus.data_out = data_c;
      assign bus.lane_sel = lane_sel_c;
    end
  endgenerate

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench: four demux variants share one stimulus stream and are compared
// against a lane-array model of the routing rules.
module tb_demux_1to4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] din = '0;
  logic [1:0] sel = '0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] lane_nh [4];   // registered, HOLD=0
  logic [7:0] lane_h  [4];   // registered, HOLD=1
  logic [3:0] sel_m;

  always #5 clk = ~clk;

  demux_1to4_if #(.DATA_W(1)) if_a ();
  demux_1to4_if #(.DATA_W(8)) if_b ();
  demux_1to4_if #(.DATA_W(8)) if_c ();
  demux_1to4_if #(.DATA_W(1)) if_d ();

  assign if_a.en = en;  assign if_a.data_in = din[0];  assign if_a.select = sel;
  assign if_b.en = en;  assign if_b.data_in = din;     assign if_b.select = sel;
  assign if_c.en = en;  assign if_c.data_in = din;     assign if_c.select = sel;
  assign if_d.en = en;  assign if_d.data_in = din[0];  assign if_d.select = sel;

  demux_1to4 #(.DATA_W(1), .REG_OUT(1), .HOLD(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  demux_1to4 #(.DATA_W(8), .REG_OUT(1), .HOLD(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  demux_1to4 #(.DATA_W(8), .REG_OUT(1), .HOLD(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
  demux_1to4 #(.DATA_W(1), .REG_OUT(0), .HOLD(1)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack8(input logic [7:0] l [4]);
    return {l[3], l[2], l[1], l[0]};
  endfunction

  function automatic logic [31:0] pack1(input logic [7:0] l [4]);
    return {28'd0, l[3][0], l[2][0], l[1][0], l[0][0]};
  endfunction

  // Apply the current inputs for one clock; check the combinational variant before the
  // edge and the registered variants just after it.
  task automatic step();
    logic [3:0] sel_now;
    logic [3:0] comb_exp;
    #1;
    sel_now  = en ? (4'b0001 << sel) : 4'b0000;
    comb_exp = en ? ({3'b000, din[0]} << sel) : 4'b0000;
    check("comb_data", {28'd0, if_d.data_out}, {28'd0, comb_exp});
    check("comb_sel",  {28'd0, if_d.lane_sel}, {28'd0, sel_now});
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin lane_nh[k] = '0; lane_h[k] = '0; end
      sel_m = '0;
    end else begin
      for (int k = 0; k < 4; k++) lane_nh[k] = '0;
      if (en) begin
        lane_nh[sel] = din;
        lane_h[sel]  = din;
      end
      sel_m = sel_now;
    end
    #1;
    check("a_data", {28'd0, if_a.data_out}, pack1(lane_nh));
    check("a_sel",  {28'd0, if_a.lane_sel}, {28'd0, sel_m});
    check("b_data", if_b.data_out, pack8(lane_nh));
    check("b_sel",  {28'd0, if_b.lane_sel}, {28'd0, sel_m});
    check("c_data", if_c.data_out, pack8(lane_h));
    check("c_sel",  {28'd0, if_c.lane_sel}, {28'd0, sel_m});
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin lane_nh[k] = '0; lane_h[k] = '0; end
    sel_m = '0;

    // Reset held two cycles with live inputs; the combinational variant ignores rst.
    rst = 1'b1; en = 1'b1; din = 8'h01; sel = 2'd1;
    step();
    step();
    check("rst_a_zero", {28'd0, if_a.data_out}, 32'd0);
    check("rst_comb_live", {28'd0, if_d.data_out}, 32'h2);

    // Sweep with data 1, then data 0 (lane_sel still flags the lane).
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); din = 8'h01;
      step();
    end
    check("sweep1_last", {28'd0, if_a.data_out}, 32'h8);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); din = 8'h00;
      step();
    end
    check("sweep0_sel", {28'd0, if_a.lane_sel}, 32'h8);

    // Wide word on the top lane.
    sel = 2'd3; din = 8'hA5;
    step();
    check("wide_a5", if_b.data_out, 32'hA500_0000);

    // Hold variant: two lanes accumulate, then en=0 freezes them.
    rst = 1'b1; step();
    rst = 1'b0;
    sel = 2'd0; din = 8'h11; step();
    sel = 2'd2; din = 8'h22; step();
    check("hold_pair", if_c.data_out, 32'h0022_0011);
    en = 1'b0; din = 8'hFF; step();
    check("hold_frozen", if_c.data_out, 32'h0022_0011);
    check("hold_sel_off", {28'd0, if_c.lane_sel}, 32'd0);
    check("nohold_off", if_b.data_out, 32'd0);

    // Reset mid-stream discards the word in flight.
    en = 1'b1; sel = 2'd1; din = 8'h5A; step();
    rst = 1'b1; sel = 2'd3; din = 8'h77; step();
    check("midrst_b", if_b.data_out, 32'd0);
    rst = 1'b0;

    // Randomized traffic with occasional reset and en drop.
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      en  = ($urandom_range(0, 4) != 0);
      sel = 2'($urandom_range(0, 3));
      din = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
